// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : glitch_sequencer
// Brief   : In-line bus fault injector: delay, N pulses of stuck/xor/random
//           corruption separated by gaps. Optional LFSR: GLITCH_SEQ_LFSR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module glitch_sequencer #(
    parameter int          BIT_LENGTH = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2BAD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIT_LENGTH-1:0] in,
    output logic [BIT_LENGTH-1:0] out,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [BIT_LENGTH-1:0] value,
    input  logic [CNT_WIDTH-1:0]  delay,
    input  logic [CNT_WIDTH-1:0]  duration,
    input  logic [CNT_WIDTH-1:0]  gap,
    input  logic [7:0]            pulses,
    output logic                  busy,
    output logic                  active,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_DELAY  = 3'd2,
        S_GLITCH = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [BIT_LENGTH-1:0] r_value;
    logic [CNT_WIDTH-1:0]  r_delay;
    logic [CNT_WIDTH-1:0]  r_dur;
    logic [CNT_WIDTH-1:0]  r_gap;
    logic [7:0]            r_pulses;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [7:0]            r_left;
    logic                  r_fin;
    logic                  r_done;
    logic [BIT_LENGTH-1:0] r_out;
    logic                  r_active;
    logic [BIT_LENGTH-1:0] w_corrupt;

`ifdef GLITCH_SEQ_LFSR_EN
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

    logic [31:0]           r_lfsr;
    logic [BIT_LENGTH-1:0] r_held;
    logic [BIT_LENGTH-1:0] w_lfsr_word;
    logic [BIT_LENGTH-1:0] w_rand_held;
    logic                  w_first;

    genvar gi;
    generate
        for (gi = 0; gi < BIT_LENGTH; gi++) begin : g_lfsr_rep
            assign w_lfsr_word[gi] = r_lfsr[gi % 32];
        end
    endgenerate

    // The counter is reloaded with dur-1 on every pulse entry, so this marks a pulse's first edge
    assign w_first     = (r_cnt == (r_dur - c_CNT_ONE));
    assign w_rand_held = w_first ? w_lfsr_word : r_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 32'h0);
        end
    end
`endif

    always_comb begin
        w_corrupt = in ^ r_value;
        case (r_mode)
            2'd0:    w_corrupt = r_value;
            2'd1:    w_corrupt = in ^ r_value;
`ifdef GLITCH_SEQ_LFSR_EN
            2'd2:    w_corrupt = w_lfsr_word;
            2'd3:    w_corrupt = w_rand_held;
`endif
            default: w_corrupt = in ^ r_value;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_value  <= '0;
            r_delay  <= '0;
            r_dur    <= '0;
            r_gap    <= '0;
            r_pulses <= '0;
            r_cnt    <= '0;
            r_left   <= '0;
            r_fin    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_fin && !abort;
            r_fin  <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_mode   <= mode;
                            r_value  <= value;
                            r_delay  <= delay;
                            r_dur    <= (duration == '0) ? c_CNT_ONE : duration;
                            r_gap    <= gap;
                            r_pulses <= (pulses == 8'd0) ? 8'd1 : pulses;
                            r_state  <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (trigger) begin
                            r_left <= r_pulses;
                            if (r_delay != '0) begin
                                r_cnt   <= r_delay - c_CNT_ONE;
                                r_state <= S_DELAY;
                            end else begin
                                r_cnt   <= r_dur - c_CNT_ONE;
                                r_state <= S_GLITCH;
                            end
                        end
                    end
                    S_DELAY, S_GAP: begin
                        if (r_cnt == '0) begin
                            r_cnt   <= r_dur - c_CNT_ONE;
                            r_state <= S_GLITCH;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                    S_GLITCH: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end else if (r_left == 8'd1) begin
                            r_fin   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_left <= r_left - 8'd1;
                            if (r_gap != '0) begin
                                r_cnt   <= r_gap - c_CNT_ONE;
                                r_state <= S_GAP;
                            end else begin
                                r_cnt <= r_dur - c_CNT_ONE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Corruption follows the state held before the edge, so an abort edge still corrupts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_active <= 1'b0;
`ifdef GLITCH_SEQ_LFSR_EN
            r_held   <= '0;
`endif
        end else begin
            if (r_state == S_GLITCH) begin
                r_out    <= w_corrupt;
                r_active <= 1'b1;
            end else begin
                r_out    <= in;
                r_active <= 1'b0;
            end
`ifdef GLITCH_SEQ_LFSR_EN
            if (r_state == S_GLITCH) begin
                r_held <= w_rand_held;
            end
`endif
        end
    end

    assign out    = r_out;
    assign active = r_active;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/glitch_sequencer.md
# glitch_sequencer

Programmable, cycle-accurate fault injector for the dual-core glitch-protection testbench. It is inserted in series with any core-side signal bus. Once armed and triggered, it corrupts the bus for a scheduled window: a delay, then a set number of glitch pulses of set length separated by gaps. Corruption is stuck-value, XOR bit-flip, or pseudo-random. Between windows the bus passes through with one register of latency.

## Interface
Parameters:
- BIT_LENGTH, 32, width of the intercepted bus.
- CNT_WIDTH, 16, width of the delay/duration/gap counters.
- LFSR_SEED, 32'hACE1_2BAD, reset value of the internal LFSR; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in  in  BIT_LENGTH  clean signal.
- out  out  BIT_LENGTH  registered, possibly corrupted signal.
- arm  in  1  in IDLE, latches all config inputs and enters ARMED.
- trigger  in  1  in ARMED, starts the schedule.
- abort  in  1  returns to IDLE from any state.
- mode  in  2  corruption type: 0 stuck, 1 xor, 2 random-per-cycle, 3 random-held.
- value  in  BIT_LENGTH  stuck value (mode 0) or flip mask (mode 1).
- delay  in  CNT_WIDTH  cycles from trigger to the first glitch.
- duration  in  CNT_WIDTH  glitched edges per pulse; 0 is treated as 1.
- gap  in  CNT_WIDTH  clean edges between pulses.
- pulses  in  8  number of pulses; 0 is treated as 1.
- busy  out  1  high in ARMED, DELAY, GLITCH and GAP.
- active  out  1  high during edges whose registered out is corrupted (registered, aligned with out).
- done  out  1  one-cycle pulse when the schedule completes (not on abort).

## Operation
- States: IDLE, ARMED, DELAY, GLITCH, GAP.
- IDLE:
  - If arm is high: latch config, go to ARMED.
  - Trigger is ignored, including when it is high in the same cycle as arm.
- ARMED:
  - If trigger is high: go to DELAY if delay > 0, else go to GLITCH.
  - Arm is ignored in every non-IDLE state.
- DELAY: counts delay edges, then goes to GLITCH.
- GLITCH:
  - Stays for duration edges, then decrements the remaining-pulse counter.
  - If pulses remain: go to GAP, or straight back to GLITCH when gap = 0.
  - If no pulses remain: go to IDLE with done = 1.
- GAP: counts gap edges, then goes to GLITCH.
- abort: has priority over everything except reset. Next state is IDLE, no done pulse, and out passes through from the next edge.
- out update at every edge:
  - Not in GLITCH: out ← in.
  - In GLITCH, mode 0: out ← value.
  - In GLITCH, mode 1: out ← in ^ value.
  - In GLITCH, mode 2: out ← current LFSR word.
  - In GLITCH, mode 3: out ← LFSR word captured on the first edge of each pulse, held for that pulse.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances every non-reset edge, independent of state.
  - Its word is replicated and truncated to BIT_LENGTH.
- Counters are CNT_WIDTH unsigned values loaded from the latched config, so there is no wrap-around. The maximum window is 2^CNT_WIDTH−1 edges.

## Timing
- Reset values:
  - out = 0, busy = 0, active = 0, done = 0.
  - State = IDLE.
  - LFSR = LFSR_SEED.
  - Latched config = 0.
- Reset mid-schedule ends injection at that edge. No done pulse is issued.
- Pass-through latency is 1 cycle: out at edge E+1 equals in sampled at edge E.
- Trigger sampled at edge T gives corrupted edges T+delay+1 … T+delay+duration for pulse 1. Pulse k starts duration+gap edges after pulse k−1 starts.
- done is high for the one cycle after the last corrupted edge, simultaneous with the first clean out.
- Re-arming is accepted in the cycle after done.
- Changing config inputs while busy has no effect.

## Configuration
- `GLITCH_SEQ_LFSR_EN`:
  - Defined: LFSR present; modes 2 and 3 behave as above.
  - Undefined: LFSR removed; modes 2 and 3 behave as mode 1 (xor with value).

## Test plan
- Pass-through: idle, in = 32'h1234_5678 → out = 32'h1234_5678 one cycle later; active = 0.
- Stuck: arm with mode 0, value = 32'hDEAD_BEEF, delay = 3, duration = 2, pulses = 1; trigger at edge T → out = DEADBEEF exactly at T+4 and T+5; done high at T+6.
- Multi-pulse xor: mode 1, value = 32'h1, delay = 0, duration = 1, gap = 2, pulses = 3 → LSB flipped at T+1, T+4 and T+7 only; done at T+8.
- Random-held: mode 3, duration = 4 → out is constant and nonzero across the 4 glitched edges. Reset replay reproduces the identical word from LFSR_SEED.
- Abort: abort asserted at the 2nd edge of a 5-edge pulse → out clean from the next edge, busy = 0, done never pulses.
- Edge cases:
  - arm and trigger in the same cycle → only arm takes effect.
  - Reset mid-GLITCH → out = 0, state IDLE.
  - duration = 0, pulses = 0 → exactly one glitched edge.
